// File: rtl/parity_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : parity_frame_checker_if
// Brief   : Serial frame input and word/status output bundle for the checker.
// Rev     : 1.0  initial release
// ============================================================================
interface parity_frame_checker_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic              bit_in;
   logic              bit_valid;
   logic [DATA_W-1:0] data_out;
   logic              parity_err;
   logic              data_valid;
   logic              frame_abort;
   logic              busy;

   modport master (
      output start, bit_in, bit_valid,
      input  data_out, parity_err, data_valid, frame_abort, busy
   );

   modport slave (
      input  start, bit_in, bit_valid,
      output data_out, parity_err, data_valid, frame_abort, busy
   );
endinterface
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module  : parity_frame_checker
// Brief   : Receives start + DATA_W LSB-first bits + parity, reports word/error.
// Rev     : 1.0  initial release
// ============================================================================
module parity_frame_checker #(
   parameter int DATA_W = 8,
   parameter int ODD    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   parity_frame_checker_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic             ODD_BIT  = (ODD != 0);

   state_t              state, state_next;
   logic [DATA_W-1:0]   sr, sr_next, sr_shift;
   logic                acc, acc_next;
   logic [CNT_W-1:0]    count, count_next;
   logic [DATA_W-1:0]   data_q, data_next;
   logic                perr_q, perr_next;
   logic                dv_q, dv_next;
   logic                abort_q, abort_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         acc     <= 1'b0;
         count   <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         dv_q    <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_next;
         sr      <= sr_next;
         acc     <= acc_next;
         count   <= count_next;
         data_q  <= data_next;
         perr_q  <= perr_next;
         dv_q    <= dv_next;
         abort_q <= abort_next;
      end
   end

   always_comb begin
      state_next = state;
      sr_next    = sr;
      acc_next   = acc;
      count_next = count;
      data_next  = data_q;
      perr_next  = perr_q;
      dv_next    = 1'b0;
      abort_next = 1'b0;
      // Written this way so DATA_W = 1 needs no zero-width slice
      sr_shift   = sr >> 1;
      sr_shift[DATA_W-1] = bus.bit_in;

      // start overrides any bit on the same cycle, including the parity bit
      if (bus.start) begin
         abort_next = (state != IDLE);
         state_next = DATA;
         sr_next    = '0;
         acc_next   = 1'b0;
         count_next = '0;
      end else begin
         case (state)
            DATA: begin
               if (bus.bit_valid) begin
                  sr_next    = sr_shift;
                  acc_next   = acc ^ bus.bit_in;
                  count_next = count + CNT_W'(1);
                  if (count == LAST_BIT) begin
                     state_next = PARITY;
                  end
               end
            end
            PARITY: begin
               if (bus.bit_valid) begin
                  data_next  = sr;
                  perr_next  = acc ^ bus.bit_in ^ ODD_BIT;
                  dv_next    = 1'b1;
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   assign bus.data_out    = data_q;
   assign bus.parity_err  = perr_q;
   assign bus.data_valid  = dv_q;
   assign bus.frame_abort = abort_q;
   assign bus.busy        = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_parity_frame_checker
// Brief   : Directed bench; even (dut0) and odd (dut1) checkers share stimulus.
// Rev     : 1.0  initial release
// ============================================================================
module tb_parity_frame_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   dv_cnt = 0;
   int   fa_cnt = 0;
   int   busy_low = 0;
   logic busy_mon = 1'b0;

   parity_frame_checker_if #(.DATA_W(8)) bus0 ();
   parity_frame_checker_if #(.DATA_W(8)) bus1 ();

   assign bus1.start     = bus0.start;
   assign bus1.bit_in    = bus0.bit_in;
   assign bus1.bit_valid = bus0.bit_valid;

   parity_frame_checker #(.DATA_W(8), .ODD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   parity_frame_checker #(.DATA_W(8), .ODD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus0.data_valid)  dv_cnt++;
      if (bus0.frame_abort) fa_cnt++;
      if (busy_mon && !bus0.busy) busy_low++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input bit gapped);
      if (gapped) repeat ($urandom_range(1, 3)) tick();
      bus0.bit_in    = b;
      bus0.bit_valid = 1'b1;
      tick();
      bus0.bit_valid = 1'b0;
   endtask

   // Data bits LSB-first then the parity bit; leaves the bench just after the parity edge
   task automatic send_body(input logic [7:0] word, input logic par, input bit gapped);
      for (int i = 0; i < 8; i++) send_bit(word[i], gapped);
      send_bit(par, gapped);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (bus0.data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", bus0.parity_err); end
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus0.data_valid); end
      checks++; if (bus0.frame_abort !== 1'b0) begin errors++; $display("FAIL reset_fa got %b want 0", bus0.frame_abort); end
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
   endtask

   task automatic test_basic();
      do_start();
      checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", bus0.busy); end
      send_body(8'hA5, 1'b0, 1'b0);
      checks++; if (bus0.data_valid !== 1'b1) begin errors++; $display("FAIL basic_dv got %b want 1", bus0.data_valid); end
      checks++; if (bus0.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr_even got %b want 0", bus0.parity_err); end
      checks++; if (bus1.parity_err !== 1'b1) begin errors++; $display("FAIL basic_perr_odd got %b want 1", bus1.parity_err); end
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", bus0.busy); end
      tick();
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL basic_dv_width got %b want 0", bus0.data_valid); end
      checks++; if (bus0.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_hold got %h want a5", bus0.data_out); end
   endtask

   task automatic test_parity_err();
      do_start();
      send_body(8'h07, 1'b0, 1'b0);
      checks++; if (bus0.data_out !== 8'h07) begin errors++; $display("FAIL perr_data got %h want 07", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b1) begin errors++; $display("FAIL perr_even got %b want 1", bus0.parity_err); end
      checks++; if (bus1.parity_err !== 1'b0) begin errors++; $display("FAIL perr_odd got %b want 0", bus1.parity_err); end
      tick();
   endtask

   task automatic test_gapped();
      int dv0;
      tick();
      dv0 = dv_cnt;
      do_start();
      busy_low = 0;
      busy_mon = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i), 1'b1);
      repeat ($urandom_range(1, 3)) tick();
      busy_mon = 1'b0;
      send_bit(1'b0, 1'b0);
      checks++; if (busy_low !== 0) begin errors++; $display("FAIL gap_busy low_cycles %0d want 0", busy_low); end
      checks++; if (bus0.data_out !== 8'h3C) begin errors++; $display("FAIL gap_data got %h want 3c", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL gap_perr got %b want 0", bus0.parity_err); end
      tick();
      tick();
      checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL gap_dv_count got %0d want 1", dv_cnt - dv0); end
   endtask

   task automatic test_abort();
      int fa0;
      fa0 = fa_cnt;
      do_start();
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      do_start();
      checks++; if (bus0.frame_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b want 1", bus0.frame_abort); end
      checks++; if (bus0.data_out !== 8'h3C) begin errors++; $display("FAIL abort_data_hold got %h want 3c", bus0.data_out); end
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL abort_dv got %b want 0", bus0.data_valid); end
      tick();
      checks++; if (bus0.frame_abort !== 1'b0) begin errors++; $display("FAIL abort_width got %b want 0", bus0.frame_abort); end
      checks++; if (fa_cnt - fa0 !== 1) begin errors++; $display("FAIL abort_count got %0d want 1", fa_cnt - fa0); end
      send_body(8'hFF, 1'b0, 1'b0);
      checks++; if (bus0.data_out !== 8'hFF) begin errors++; $display("FAIL abort_next_data got %h want ff", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL abort_next_perr got %b want 0", bus0.parity_err); end
      tick();
   endtask

   task automatic test_reset_mid();
      int dv0;
      do_start();
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus0.data_out !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", bus0.data_out); end
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus0.busy); end
      checks++; if (bus0.frame_abort !== 1'b0) begin errors++; $display("FAIL rmid_fa got %b want 0", bus0.frame_abort); end
      dv0 = dv_cnt;
      for (int i = 0; i < 10; i++) send_bit(1'(i & 1), 1'b0);
      tick();
      checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL rmid_stray_dv got %0d want %0d", dv_cnt, dv0); end
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rmid_stray_busy got %b want 0", bus0.busy); end
      do_start();
      send_body(8'h81, 1'b0, 1'b0);
      checks++; if (bus0.data_out !== 8'h81) begin errors++; $display("FAIL rmid_data2 got %h want 81", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL rmid_perr2 got %b want 0", bus0.parity_err); end
      tick();
   endtask

   task automatic test_collision();
      do_start();
      for (int i = 0; i < 8; i++) send_bit(1'(8'h5A >> i), 1'b0);
      bus0.start     = 1'b1;
      bus0.bit_in    = 1'b0;
      bus0.bit_valid = 1'b1;
      tick();
      bus0.start     = 1'b0;
      bus0.bit_valid = 1'b0;
      checks++; if (bus0.frame_abort !== 1'b1) begin errors++; $display("FAIL coll_fa got %b want 1", bus0.frame_abort); end
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL coll_dv got %b want 0", bus0.data_valid); end
      checks++; if (bus0.data_out !== 8'h81) begin errors++; $display("FAIL coll_data_hold got %h want 81", bus0.data_out); end
      checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL coll_busy got %b want 1", bus0.busy); end
      send_body(8'h12, 1'b1, 1'b0);
      checks++; if (bus0.data_out !== 8'h12) begin errors++; $display("FAIL coll_next_data got %h want 12", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b1) begin errors++; $display("FAIL coll_perr_even got %b want 1", bus0.parity_err); end
      checks++; if (bus1.parity_err !== 1'b0) begin errors++; $display("FAIL coll_perr_odd got %b want 0", bus1.parity_err); end
   endtask

   task automatic test_back_to_back();
      // Entered on the data_valid cycle of the previous frame
      do_start();
      checks++; if (bus0.frame_abort !== 1'b0) begin errors++; $display("FAIL b2b_fa got %b want 0", bus0.frame_abort); end
      checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", bus0.busy); end
      send_body(8'hF0, 1'b1, 1'b0);
      checks++; if (bus0.data_valid !== 1'b1) begin errors++; $display("FAIL b2b_dv got %b want 1", bus0.data_valid); end
      checks++; if (bus0.data_out !== 8'hF0) begin errors++; $display("FAIL b2b_data got %h want f0", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b1) begin errors++; $display("FAIL b2b_perr_even got %b want 1", bus0.parity_err); end
      checks++; if (bus1.parity_err !== 1'b0) begin errors++; $display("FAIL b2b_perr_odd got %b want 0", bus1.parity_err); end
      do_start();
      send_body(8'h01, 1'b1, 1'b0);
      checks++; if (bus0.data_out !== 8'h01) begin errors++; $display("FAIL b2b_data2 got %h want 01", bus0.data_out); end
      checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL b2b_perr2 got %b want 0", bus0.parity_err); end
      tick();
   endtask

   initial begin
      bus0.start     = 1'b0;
      bus0.bit_in    = 1'b0;
      bus0.bit_valid = 1'b0;
      test_reset();
      test_basic();
      test_parity_err();
      test_gapped();
      test_abort();
      test_reset_mid();
      test_collision();
      test_back_to_back();
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial receive-side parity checker for the logic-gate library. Accepts a framed serial bit stream (start strobe, DATA_W data bits LSB-first, one parity bit) qualified by a valid strobe. Accumulates the XOR of the data bits, assembles the data word and checks the received parity bit against the configured even/odd sense. Sits downstream of any XOR-based serial parity generator and reports the word plus an error flag once per frame.

## Interface
- DATA_W, 8, data bits per frame (1..32)
- ODD, 0, parity sense: 0 = even (XOR of data+parity must be 0), 1 = odd (must be 1)

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  frame start strobe; begins a new frame (aborts any frame in progress)
- bit_in  input  1  serial data/parity bit, sampled only when bit_valid=1
- bit_valid  input  1  qualifies bit_in
- data_out  output  DATA_W  last completed frame's data word (bit 0 = first received bit)
- parity_err  output  1  parity result of last completed frame (1 = mismatch)
- data_valid  output  1  one-cycle pulse: data_out/parity_err updated
- frame_abort  output  1  one-cycle pulse: in-progress frame discarded by start
- busy  output  1  high in DATA or PARITY state

## Operation
- States: IDLE, DATA, PARITY. Internal: shift register sr[DATA_W-1:0], acc (1 bit), count (clog2(DATA_W+1) bits).
- IDLE: start=1 -> DATA, sr=0, acc=0, count=0. bit_valid ignored in IDLE and on the start cycle itself.
- DATA: on bit_valid=1, sr = {bit_in, sr[DATA_W-1:1]} (LSB-first, first bit lands in bit 0 after DATA_W shifts), acc = acc ^ bit_in, count+1. When the DATA_W-th bit is accepted -> PARITY.
- PARITY: on bit_valid=1, data_out=sr, parity_err = acc ^ bit_in ^ ODD, data_valid=1 next cycle, -> IDLE.
- bit_valid=0 in DATA/PARITY: hold all state; no timeout.
- start=1 in DATA or PARITY: frame_abort=1 next cycle, bit on that cycle ignored, re-enter DATA with sr/acc/count cleared. data_out/parity_err unchanged.
- start and the final parity bit on the same cycle: start wins; frame aborted, no data_valid.
- busy = (state != IDLE).

## Timing
- Reset (rst=1 at a clock edge, any state): state=IDLE, data_out=0, parity_err=0, data_valid=0, frame_abort=0, busy=0, sr/acc/count=0. Reset mid-frame discards the frame with no pulse.
- busy rises the cycle after start is sampled.
- data_valid and frame_abort are registered, high exactly one cycle, the cycle after the triggering edge.
- data_out/parity_err change only with data_valid and hold until the next data_valid or reset.
- Minimum frame: 1 start cycle + DATA_W + 1 valid cycles; back-to-back frames allowed (start may be asserted on the cycle data_valid is high).

## Test plan
- DATA_W=8, ODD=0: start, then bits 1,0,1,0,0,1,0,1 (0xA5), parity 0 -> data_valid pulse, data_out=0xA5, parity_err=0.
- DATA_W=8, ODD=0: send 0x07 with parity 0 -> data_out=0x07, parity_err=1; repeat with ODD=1 -> parity_err=0.
- Gapped stream: 0x3C with bit_valid low for 1-3 random cycles between bits, parity 0 -> data_out=0x3C, parity_err=0, busy high throughout, exactly one data_valid.
- Abort: start, 3 bits, start again -> frame_abort one cycle, data_out unchanged; then 0xFF parity 0 -> data_out=0xFF, parity_err=0.
- Reset mid-frame: start, 5 bits, rst=1 one cycle -> all outputs 0, busy=0; stray bit_valid in IDLE produces no data_valid; subsequent full frame 0x81 parity 0 -> data_out=0x81, parity_err=0.
- Start/parity collision: assert start on the parity-bit cycle -> frame_abort pulse, no data_valid, new frame proceeds normally.
